spi_ram_ctrl: RTL and testbench

- Command-decoding RAM stage directly downstream of the SPI slave FSM.
- Consumes the slave's 10-bit rx_data/rx_valid words and executes write-address, write-data, read-address and read-data commands against an internal single-port byte memory.
- Returns read bytes on tx_data/tx_valid, which feed back into the slave for shifting out on MISO.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_ram_array.sv | 19 +
 rtl/spi_ram_ctrl.sv | 86 ++++++++
 tb/tb_spi_ram_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: command codes, read-FSM encoding and default memory geometry shared by the SPI slave path.
package spi_pkg;
    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_ADDR_SIZE = 8;
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;
    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_ARMED = 1'b1
    } rd_state_e;
endpackage

// File: rtl/spi_ram_array.sv
// spi_ram_array: synchronous single-port byte RAM with registered read-first output.
module spi_ram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);
    logic [7:0] mem [DEPTH];
    logic [7:0] dout_q;
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout_q <= mem[addr];
    end
    assign dout = dout_q;
endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes SPI slave command words into RAM writes/reads and returns read bytes to the slave.
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [9:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       cmd_err
);
    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] addr_pl;
    rd_state_e            state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_addr;
    logic                 rd_pend_q, rd_pend_d, tx_valid_q, tx_valid_d, cmd_err_q, cmd_err_d;
    logic [7:0]           tx_data_q, tx_data_d, ram_dout;
    logic                 wr_fire, rd_fire, rd_err, wa_fire, ra_fire;

    assign cmd     = cmd_e'(rx_data[9:8]);
    assign addr_pl = ADDR_SIZE'(rx_data[7:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RD_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rx_valid && cmd == CMD_RD_ADDR) state_d = RD_ARMED;
    end

    always_comb begin
        wa_fire  = rx_valid && cmd == CMD_WR_ADDR;
        wr_fire  = rx_valid && cmd == CMD_WR_DATA;
        ra_fire  = rx_valid && cmd == CMD_RD_ADDR;
        rd_fire  = rx_valid && cmd == CMD_RD_DATA && state_q == RD_ARMED;
        rd_err   = rx_valid && cmd == CMD_RD_DATA && state_q == RD_IDLE;
        ram_addr = wr_fire ? wr_ptr_q : rd_ptr_q;
    end

    // rd_pend tracks the RAM read stage so tx_valid lands one cycle after the RAM output register.
    always_comb begin
        wr_ptr_d   = wa_fire ? addr_pl : (wr_fire && AUTO_INC) ? wr_ptr_q + ADDR_SIZE'(1) : wr_ptr_q;
        rd_ptr_d   = ra_fire ? addr_pl : (rd_fire && AUTO_INC) ? rd_ptr_q + ADDR_SIZE'(1) : rd_ptr_q;
        rd_pend_d  = rd_fire;
        tx_valid_d = rd_pend_q;
        tx_data_d  = rd_pend_q ? ram_dout : tx_data_q;
        cmd_err_d  = rd_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_pend_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            cmd_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_pend_q  <= rd_pend_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    spi_ram_array #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE)) u_ram (
        .clk  (clk),
        .we   (wr_fire),
        .addr (ram_addr),
        .din  (rx_data[7:0]),
        .dout (ram_dout)
    );

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed vector table plus hand sequences for wrap, idle gaps, reset mid-read and AUTO_INC=0.
module tb_spi_ram_ctrl;
    localparam logic [1:0] WA = 2'b00, WD = 2'b01, RA = 2'b10, RD = 2'b11;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] pl;
        logic       v;
        logic       tv;
        logic [7:0] td;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_data = '0;
    logic [7:0] tx_data, tx_data0;
    logic       tx_valid, tx_valid0, cmd_err, cmd_err0;
    int         n_chk = 0;
    int         n_fail = 0;
    vec_t       tbl[22];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .cmd_err(cmd_err)
    );

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .cmd_err(cmd_err0)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [7:0] p, input logic v);
        @(negedge clk);
        rx_valid = v;
        rx_data  = {c, p};
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic tv, input logic [7:0] td, input logic err);
        chk({name, ".tx_valid"}, {7'd0, tx_valid}, {7'd0, tv});
        chk({name, ".tx_data"}, tx_data, td);
        chk({name, ".cmd_err"}, {7'd0, cmd_err}, {7'd0, err});
    endtask

    task automatic chk_out0(input string name, input logic tv, input logic [7:0] td);
        chk({name, ".tx_valid0"}, {7'd0, tx_valid0}, {7'd0, tv});
        chk({name, ".tx_data0"}, tx_data0, td);
    endtask

    initial begin
        tbl[0]  = '{RD, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[1]  = '{RD, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{WA, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{WD, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{RA, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{RD, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{WD, 8'hEE, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[7]  = '{RA, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[8]  = '{WA, 8'hFF, 1'b1, 1'b0, 8'hA5, 1'b0};
        tbl[9]  = '{WD, 8'h11, 1'b1, 1'b0, 8'hA5, 1'b0};
        tbl[10] = '{WD, 8'h22, 1'b1, 1'b0, 8'hA5, 1'b0};
        tbl[11] = '{RA, 8'hFF, 1'b1, 1'b0, 8'hA5, 1'b0};
        tbl[12] = '{RD, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0};
        tbl[13] = '{RD, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[14] = '{RD, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0};
        tbl[15] = '{WD, 8'hEE, 1'b0, 1'b0, 8'h22, 1'b0};
        tbl[16] = '{RA, 8'h30, 1'b1, 1'b0, 8'h22, 1'b0};
        tbl[17] = '{WA, 8'h30, 1'b1, 1'b0, 8'h22, 1'b0};
        tbl[18] = '{WD, 8'h5C, 1'b1, 1'b0, 8'h22, 1'b0};
        tbl[19] = '{RD, 8'h00, 1'b1, 1'b0, 8'h22, 1'b0};
        tbl[20] = '{WA, 8'h77, 1'b0, 1'b1, 8'h5C, 1'b0};
        tbl[21] = '{RD, 8'h00, 1'b0, 1'b0, 8'h5C, 1'b0};

        // Reset state
        #12;
        chk_out("reset", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].cmd, tbl[i].pl, tbl[i].v);
            chk_out($sformatf("vec%0d", i), tbl[i].tv, tbl[i].td, tbl[i].err);
        end

        // Idle gap: nothing may move while rx_valid is low
        step(WA, 8'h40, 1'b1);
        step(WD, 8'h99, 1'b1);
        step(RA, 8'h40, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(2'($urandom), 8'($urandom), 1'b0);
            chk_out($sformatf("gap%0d", i), 1'b0, 8'h5C, 1'b0);
        end
        step(RD, 8'h00, 1'b1);
        chk_out("gap_rd0", 1'b0, 8'h5C, 1'b0);
        step(WD, 8'h42, 1'b1);
        chk_out("gap_rd0_out", 1'b1, 8'h99, 1'b0);
        step(RD, 8'h00, 1'b1);
        chk_out("gap_wr", 1'b0, 8'h99, 1'b0);
        step(RD, 8'h00, 1'b0);
        chk_out("gap_rd1_out", 1'b1, 8'h42, 1'b0);

        // Reset mid-read
        step(RA, 8'h05, 1'b1);
        step(RD, 8'h00, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk_out("rst_hold", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(WA, 8'h00, 1'b0);
            chk_out($sformatf("rst_post%0d", i), 1'b0, 8'h00, 1'b0);
        end
        step(RD, 8'h00, 1'b1);
        chk_out("rst_rd_err", 1'b0, 8'h00, 1'b1);
        step(RD, 8'h00, 1'b0);
        chk_out("rst_rd_err_end", 1'b0, 8'h00, 1'b0);

        // AUTO_INC=0 instance holds pointers; AUTO_INC=1 instance checked alongside
        step(WA, 8'h04, 1'b1);
        step(WD, 8'h77, 1'b1);
        step(WA, 8'h03, 1'b1);
        step(WD, 8'h01, 1'b1);
        step(WD, 8'h02, 1'b1);
        step(RA, 8'h03, 1'b1);
        step(RD, 8'h00, 1'b1);
        chk_out0("ni_rd0", 1'b0, 8'h00);
        step(RD, 8'h00, 1'b1);
        chk_out0("ni_rd0_out", 1'b1, 8'h02);
        chk_out("ai_rd0_out", 1'b1, 8'h01, 1'b0);
        step(RD, 8'h00, 1'b0);
        chk_out0("ni_rd1_out", 1'b1, 8'h02);
        chk_out("ai_rd1_out", 1'b1, 8'h02, 1'b0);
        step(RD, 8'h00, 1'b0);
        chk_out0("ni_idle", 1'b0, 8'h02);
        step(RA, 8'h04, 1'b1);
        step(RD, 8'h00, 1'b1);
        step(RD, 8'h00, 1'b0);
        chk_out0("ni_addr4", 1'b1, 8'h77);
        chk_out("ai_addr4", 1'b1, 8'h02, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
